// File: rtl/ball_pkg.sv
// Shared constants, types and per-ball initial-state helpers for the multi-ball animation.
package ball_pkg;

    localparam int COORD_W    = 10;
    localparam int STEP_W     = 12;
    localparam int VEL_W_DFLT = 4;

    typedef logic signed [VEL_W_DFLT-1:0] vel_t;

    function automatic logic [2:0] ball_colour(input int i);
        return 3'((i % 7) + 1);
    endfunction

    function automatic logic [COORD_W-1:0] init_pos(input int res, input int i);
        return COORD_W'(res / 2 + 16 * i);
    endfunction

    function automatic int init_hvel(input int i);
        return ((i % 2) == 0) ? -(1 + i % 3) : (1 + i % 3);
    endfunction

    function automatic int init_vvel(input int i);
        return 1 + i % 2;
    endfunction

endpackage

// File: rtl/ball_axis_step.sv
// One axis of a ball move: advance by velocity, clamp to [0, MAX] and reflect on contact.
module ball_axis_step
    import ball_pkg::*;
#(
    parameter int VEL_W = VEL_W_DFLT
) (
    input  logic [COORD_W-1:0]      pos_i,
    input  logic signed [VEL_W-1:0] vel_i,
    input  logic [COORD_W-1:0]      max_i,
    output logic [COORD_W-1:0]      next_pos_o,
    output logic signed [VEL_W-1:0] next_vel_o
);

    logic signed [STEP_W-1:0] sum;
    logic signed [STEP_W-1:0] max_ext;

    always_comb begin
        sum     = $signed({{(STEP_W - COORD_W){1'b0}}, pos_i}) + STEP_W'(vel_i);
        max_ext = $signed({{(STEP_W - COORD_W){1'b0}}, max_i});
        next_pos_o = sum[COORD_W-1:0];
        next_vel_o = vel_i;
        // Sign bit or zero means the ball touched or crossed the low border.
        if (sum[STEP_W-1] || sum == '0) begin
            next_pos_o = '0;
            next_vel_o = -vel_i;
        end else if (sum >= max_ext) begin
            next_pos_o = max_i;
            next_vel_o = -vel_i;
        end
    end

endmodule

// File: rtl/multi_ball_bounce.sv
// Animates NUM_BALLS bouncing squares: vsync-driven sequential update engine plus
// a priority renderer feeding the registered RGB pins.
module multi_ball_bounce
    import ball_pkg::*;
#(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int NUM_BALLS = 4,
    parameter int BALL_SIZE = 8,
    parameter int VEL_W     = VEL_W_DFLT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       display_on,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       pause,
    output logic [2:0] rgb,
    output logic       busy
);

    localparam int IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_BALLS - 1);
    localparam logic [COORD_W-1:0] MAX_X    = COORD_W'(H_RES - BALL_SIZE);
    localparam logic [COORD_W-1:0] MAX_Y    = COORD_W'(V_RES - BALL_SIZE);
    localparam logic [COORD_W-1:0] BSZ      = COORD_W'(BALL_SIZE);

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wr_en;

    logic               vs_meta_q, vs_sync_q, vs_prev_q, armed_q, tick_q;
    logic [1:0]         fill_q;

    logic [COORD_W-1:0]      pos_x_q [NUM_BALLS];
    logic [COORD_W-1:0]      pos_y_q [NUM_BALLS];
    logic signed [VEL_W-1:0] vel_x_q [NUM_BALLS];
    logic signed [VEL_W-1:0] vel_y_q [NUM_BALLS];

    logic [COORD_W-1:0]      cur_x, cur_y, nxt_x, nxt_y;
    logic signed [VEL_W-1:0] cur_vx, cur_vy, nxt_vx, nxt_vy;

    logic [2:0]         rgb_d, rgb_q;
    logic               hit_any;
    logic [COORD_W-1:0] dx, dy;

    // Frame tick: 2-flop synchroniser, then rising-edge detector. The edge is only
    // armed once a genuine low level has propagated through the synchroniser, so a
    // vsync already high at reset release does not count as a new frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_meta_q <= 1'b0;
            vs_sync_q <= 1'b0;
            vs_prev_q <= 1'b0;
            fill_q    <= 2'b00;
            armed_q   <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            vs_meta_q <= vsync;
            vs_sync_q <= vs_meta_q;
            vs_prev_q <= vs_sync_q;
            fill_q    <= {fill_q[0], 1'b1};
            armed_q   <= armed_q | (fill_q[1] & ~vs_sync_q);
            tick_q    <= vs_sync_q & ~vs_prev_q & armed_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick_q && !pause) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end
            UPDATE: begin
                wr_en = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == UPDATE);

    always_comb begin
        cur_x  = pos_x_q[0];
        cur_y  = pos_y_q[0];
        cur_vx = vel_x_q[0];
        cur_vy = vel_y_q[0];
        for (int i = 1; i < NUM_BALLS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_x  = pos_x_q[i];
                cur_y  = pos_y_q[i];
                cur_vx = vel_x_q[i];
                cur_vy = vel_y_q[i];
            end
        end
    end

    ball_axis_step #(.VEL_W(VEL_W)) u_step_x (
        .pos_i      (cur_x),
        .vel_i      (cur_vx),
        .max_i      (MAX_X),
        .next_pos_o (nxt_x),
        .next_vel_o (nxt_vx)
    );

    ball_axis_step #(.VEL_W(VEL_W)) u_step_y (
        .pos_i      (cur_y),
        .vel_i      (cur_vy),
        .max_i      (MAX_Y),
        .next_pos_o (nxt_y),
        .next_vel_o (nxt_vy)
    );

    // Updates only happen in the few cycles after the vsync edge, i.e. in vertical blanking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                pos_x_q[i] <= init_pos(H_RES, i);
                pos_y_q[i] <= init_pos(V_RES, i);
                vel_x_q[i] <= VEL_W'(init_hvel(i));
                vel_y_q[i] <= VEL_W'(init_vvel(i));
            end
        end else begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (wr_en && idx_q == IDX_W'(i)) begin
                    pos_x_q[i] <= nxt_x;
                    pos_y_q[i] <= nxt_y;
                    vel_x_q[i] <= nxt_vx;
                    vel_y_q[i] <= nxt_vy;
                end
            end
        end
    end

    // Walk from the highest index down so the lowest-index hit is the one that sticks.
    always_comb begin
        rgb_d   = 3'b000;
        hit_any = 1'b0;
        dx      = '0;
        dy      = '0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            dx = hpos - pos_x_q[i];
            dy = vpos - pos_y_q[i];
            if (dx < BSZ && dy < BSZ) begin
                rgb_d   = ball_colour(i);
                hit_any = 1'b1;
            end
        end
        if (!hit_any && hpos[2:0] == 3'd0 && vpos[2:0] == 3'd0) begin
            rgb_d = 3'b010;
        end
        if (!display_on) begin
            rgb_d = 3'b000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q <= 3'b000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb = rgb_q;

endmodule

// File: doc/multi_ball_bounce.md
# multi_ball_bounce

Parametrised, fully synchronous successor to the single bouncing-ball demo. It animates `NUM_BALLS` independent square balls, each with its own signed velocity, and reflects and clamps them exactly at the screen borders. Positions update once per frame via a sequential per-ball update engine clocked by `clk`. The block sits between the VGA sync generator (`hpos`/`vpos`/`vsync`/`display_on`) and the RGB output pins.

## Interface
- `H_RES`, 640: visible width in pixels.
- `V_RES`, 480: visible height in pixels.
- `NUM_BALLS`, 4: ball count, 1..8.
- `BALL_SIZE`, 8: ball edge length in pixels, power of two.
- `VEL_W`, 4: signed velocity width; every |velocity| < `BALL_SIZE`.
- `clk` input 1: pixel clock.
- `reset` input 1: reset, asynchronous, active-high.
- `vsync` input 1: sync-generator vsync, active-high, asynchronous to update logic.
- `display_on` input 1: visible-area flag.
- `hpos` input 10: beam X.
- `vpos` input 10: beam Y.
- `pause` input 1: when high, frame updates are skipped.
- `rgb` output 3: {b,g,r}, registered.
- `busy` output 1: high while the update engine walks the balls.

## Operation
- Initial state, ball i:
  - x = `H_RES`/2 + 16·i, y = `V_RES`/2 + 16·i.
  - hvel = −(1 + i mod 3) for even i, +(1 + i mod 3) for odd i.
  - vvel = +(1 + i mod 2).
  - Parameters must keep every initial position inside the limits.
- Frame tick: `vsync` passes through a 2-flop synchroniser, then a rising-edge detector. Each detected edge produces one `tick`.
- FSM states IDLE, UPDATE.
  - IDLE → UPDATE on `tick` when `pause`=0. `idx` := 0, `busy` := 1.
  - UPDATE: each cycle, ball `idx` gets its x and y axis steps written back. When `idx` = `NUM_BALLS`−1 → IDLE, `busy` := 0. Otherwise `idx`++.
  - A `tick` arriving during UPDATE is ignored.
  - `tick` with `pause`=1 leaves all state unchanged.
- Axis step, per axis, with MAX = RES − `BALL_SIZE`:
  - Compute next = pos + vel in 12-bit signed.
  - If next ≤ 0: pos := 0, vel := −vel.
  - Else if next ≥ MAX: pos := MAX, vel := −vel.
  - Else pos := next, vel unchanged.
  - Both axes are independent. A corner hit flips both velocities in the same cycle.
- Render, combinational into the output register:
  - hit_i = (hpos − x_i)[9:0] < `BALL_SIZE` && (vpos − y_i)[9:0] < `BALL_SIZE`, using unsigned 10-bit wrap subtraction.
  - When balls overlap, the lowest index wins. Colour = (i mod 7) + 1, so ball 0 is red (3'b001).
  - With no ball hit, the grid (hpos[2:0]==0 && vpos[2:0]==0) drives green 3'b010. Otherwise 0.
  - `display_on`=0 forces 0.
- Position registers update only during vertical blanking, so there is no tearing.

## Timing
- Reset values:
  - `rgb`=0, `busy`=0, FSM=IDLE, `idx`=0.
  - Positions and velocities go to their initial values.
  - Synchroniser and edge flops = 0. A `vsync` already high at reset release does not generate a `tick`.
- `tick` asserts 3 `clk` edges after `vsync` rises (2 synchroniser flops plus the edge detector).
- `busy` rises the cycle after `tick` and stays high exactly `NUM_BALLS` cycles. Ball i is written at the edge ending busy-cycle i.
- `rgb` latency is 1 cycle from `hpos`/`vpos`/`display_on`.
- Reset asserted mid-UPDATE aborts immediately. After release, all balls hold their initial values.

## Structure
- Package `ball_pkg`:
  - `COORD_W`=10.
  - The colour-index function ((i mod 7)+1).
  - Typedef for a signed velocity of `VEL_W` bits.
  - Initial-position and initial-velocity functions indexed by ball number.
- Sub-module `ball_axis_step`: purely combinational, inputs (pos, vel, MAX), outputs (next_pos, next_vel). It is instantiated once per axis and shared across balls through the `idx` mux.
- Top level holds the synchroniser, FSM, position/velocity register arrays, render priority encoder and output register.

## Test plan
- Reset, default parameters → `rgb`=0, `busy`=0, ball0 at (320,240), ball1 at (336,256). Pixel (320,240) with `display_on`=1 gives `rgb`=3'b001 one cycle later.
- One `vsync` pulse, defaults → `busy` high 4 cycles starting 4 cycles after `vsync` rises. Ball0 moves to (319,241), ball1 to (338,258).
- `H_RES`=64, `V_RES`=64, `NUM_BALLS`=1 → ball0 starts at (32,32) with hvel −1, reaches x=0 on frame 32 with hvel +1, then x=1 on frame 33.
- Same configuration → y reaches MAX=56 on frame 24 with vvel −1, then y=55 on frame 25.
- `pause`=1 across 5 `vsync` pulses → positions unchanged, `busy` never rises.
- Overlap: force balls 0 and 1 to the same position → `rgb`=3'b001 there. `display_on`=0 → `rgb`=0. Grid pixel (8,8) with no ball → 3'b010.
